// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - synchronizer, stability counter and edge pulses for a raw switch input
// Optional DEBOUNCE_TOGGLE_EN adds toggle_out, a push-on/push-off latch driven by rise.
module debounce_sync #(
    parameter int   SYNC_STAGES  = 2,
    parameter int   CNT_WIDTH    = 16,
    parameter int   STABLE_COUNT = 50000,
    parameter logic INIT_LEVEL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic level_out,
    output logic rise,
    output logic fall,
    output logic busy
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic toggle_out
`endif
);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_CHECK  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   differs;

    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   level_d;
    logic                   accept;

    // Synchronizer runs every clock, independent of tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    assign differs = (s != level_out);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_out;
        accept  = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (differs) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!differs) begin
                    // Input fell back before qualifying: a bounce restarts from zero.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        accept  = 1'b1;
                        level_d = s;
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_STABLE;
            cnt_q     <= '0;
            level_out <= INIT_LEVEL;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_out <= level_d;
            rise      <= accept & s;
            fall      <= accept & ~s;
        end
    end

    assign busy = (state_q == ST_CHECK);

`ifdef DEBOUNCE_TOGGLE_EN
    // Flips on the same edge that raises rise, so it tracks level acceptance directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toggle_out <= 1'b0;
        end else if (accept && s) begin
            toggle_out <= ~toggle_out;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - directed and randomized checks of debounce_sync against a reference model
// Build with DEBOUNCE_TOGGLE_EN defined to also cover toggle_out.
module tb_debounce_sync;

    localparam int   SYNC   = 2;
    localparam int   STABLE = 4;
    localparam logic INIT   = 1'b0;

    logic clk;
    logic reset;
    logic tick;
    logic din;
    logic level_out;
    logic rise;
    logic fall;
    logic busy;
`ifdef DEBOUNCE_TOGGLE_EN
    logic toggle_out;
`endif

    int checks;
    int errors;

    debounce_sync #(
        .SYNC_STAGES (SYNC),
        .CNT_WIDTH   (8),
        .STABLE_COUNT(STABLE),
        .INIT_LEVEL  (INIT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .din      (din),
        .level_out(level_out),
        .rise     (rise),
        .fall     (fall),
        .busy     (busy)
`ifdef DEBOUNCE_TOGGLE_EN
        ,
        .toggle_out(toggle_out)
`endif
    );

    always #5 clk = ~clk;

    // Reference: s is din delayed SYNC edges; a new level is adopted once s has
    // differed from it for one entry edge plus STABLE ticked edges in a row.
    logic m_hist[$];
    logic m_level;
    logic m_waiting;
    int   m_ticks;
    logic m_rise;
    logic m_fall;
    logic m_toggle;

    task automatic mdl_reset();
        m_hist.delete();
        for (int i = 0; i < SYNC; i++) m_hist.push_back(INIT);
        m_level   = INIT;
        m_waiting = 1'b0;
        m_ticks   = 0;
        m_rise    = 1'b0;
        m_fall    = 1'b0;
        m_toggle  = 1'b0;
    endtask

    task automatic mdl_edge(input logic d, input logic t);
        logic s;
        s = m_hist.pop_front();
        m_hist.push_back(d);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s == m_level) begin
            m_waiting = 1'b0;
            m_ticks   = 0;
        end else if (!m_waiting) begin
            m_waiting = 1'b1;
        end else if (t) begin
            m_ticks++;
            if (m_ticks == STABLE) begin
                m_level   = s;
                m_rise    = s;
                m_fall    = ~s;
                m_toggle  = m_toggle ^ s;
                m_waiting = 1'b0;
                m_ticks   = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("model_level", level_out, m_level);
        chk("model_rise", rise, m_rise);
        chk("model_fall", fall, m_fall);
        chk("model_busy", busy, m_waiting);
        chk("pulse_excl", rise & fall, 0);
`ifdef DEBOUNCE_TOGGLE_EN
        chk("model_toggle", toggle_out, m_toggle);
`endif
    endtask

    task automatic step(input logic d, input logic t);
        din  = d;
        tick = t;
        @(posedge clk);
        if (reset) mdl_edge(d, t);
        #1;
        check_all();
    endtask

    task automatic settle(input logic d);
        for (int i = 0; i < 12; i++) step(d, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  found;
        bit  saw_busy;
        bit  saw_rise;
        bit  saw_fall;
        int  run;
        logic rv;

        checks = 0;
        errors = 0;
        clk    = 1'b0;
        reset  = 1'b0;
        din    = 1'b1;
        tick   = 1'b1;
        mdl_reset();

        // 1. reset held with din=1, then release
        repeat (3) step(1'b1, 1'b1);
        chk("rst_level", level_out, 0);
        chk("rst_rise", rise, 0);
        chk("rst_fall", fall, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        n = 0; found = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step(1'b1, 1'b1);
            if (rise === 1'b1) begin found = 1; n = k; end
        end
        chk("rst_release_rise_edge", n, SYNC + STABLE + 1);
        chk("rst_release_level", level_out, 1);
        settle(1'b0);

        // 2. clean press
        n = 0; found = 0; saw_fall = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step(1'b1, 1'b1);
            if (fall === 1'b1) saw_fall = 1;
            if (level_out === 1'b1) begin found = 1; n = k; end
        end
        chk("press_latency", n, 7);
        chk("press_rise_on", rise, 1);
        step(1'b1, 1'b1);
        chk("press_rise_off", rise, 0);
        chk("press_no_fall", saw_fall, 0);
        settle(1'b0);

        // 3. glitch of 3 cycles
        saw_busy = 0; saw_rise = 0;
        for (int k = 0; k < 13; k++) begin
            step((k < 3) ? 1'b1 : 1'b0, 1'b1);
            if (busy === 1'b1) saw_busy = 1;
            if (rise === 1'b1) saw_rise = 1;
        end
        chk("glitch_busy_seen", saw_busy, 1);
        chk("glitch_no_rise", saw_rise, 0);
        chk("glitch_level", level_out, 0);
        chk("glitch_busy_end", busy, 0);

        // 4. bounce 1,0,1,0 then hold 1
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        n = 0; found = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step(1'b1, 1'b1);
            if (level_out === 1'b1) begin found = 1; n = k; end
        end
        chk("bounce_latency", n, 7);
        settle(1'b0);

        // 5. tick high one cycle in three: entry at edge 3, ticks at 6,9,12,15
        n = 0; found = 0; saw_busy = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            step(1'b1, (k % 3) == 0);
            if (k == 14 && busy === 1'b1 && level_out === 1'b0) saw_busy = 1;
            if (level_out === 1'b1) begin found = 1; n = k; end
        end
        chk("tick_gate_latency", n, 15);
        chk("tick_gate_frozen", saw_busy, 1);
        settle(1'b0);

        // 6. reset during CHECK
        repeat (6) step(1'b1, 1'b1);
        chk("midrst_busy_before", busy, 1);
        reset = 1'b0;
        mdl_reset();
        #1;
        chk("midrst_level", level_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_rise", rise, 0);
        chk("midrst_fall", fall, 0);
        repeat (2) step(1'b1, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        settle(1'b0);
        chk("midrst_after_level", level_out, 0);

`ifdef DEBOUNCE_TOGGLE_EN
        chk("toggle_init", toggle_out, 0);
        settle(1'b1);
        settle(1'b0);
        chk("toggle_first", toggle_out, 1);
        settle(1'b1);
        settle(1'b0);
        chk("toggle_second", toggle_out, 0);
`endif

        // randomized runs with occasional reset
        for (int k = 0; k < 300; k++) begin
            rv  = 1'($urandom_range(0, 1));
            run = (($urandom_range(0, 3)) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 6);
            for (int j = 0; j < run; j++) begin
                step(rv, ($urandom_range(0, 3)) != 0);
            end
            if ($urandom_range(0, 60) == 0) begin
                reset = 1'b0;
                mdl_reset();
                #1;
                check_all();
                step(rv, 1'b1);
                @(negedge clk);
                reset = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
